// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
//   Groups the request/result handshake and the shared-ALU bus of the
//   shift-and-add multiply sequencer.
//   Request side : Start, Multiplicand, Multiplier -> Busy, Done, Product
//   ALU side     : ALU_FunSel, ALU_A, ALU_B, ALU_WF -> ALUOut (registered)
//   slave  modport: the sequencer
//   master modport: the requester plus the ALU (datapath side)
interface alu_mul_sequencer_if #(
    parameter int OP_WIDTH = 16
);
    localparam int PW = 2 * OP_WIDTH;

    logic                Start;
    logic [OP_WIDTH-1:0] Multiplicand;
    logic [OP_WIDTH-1:0] Multiplier;
    logic                Busy;
    logic                Done;
    logic [PW-1:0]       Product;
    logic [4:0]          ALU_FunSel;
    logic [PW-1:0]       ALU_A;
    logic [PW-1:0]       ALU_B;
    logic                ALU_WF;
    logic [PW-1:0]       ALUOut;

    modport slave (
        input  Start, Multiplicand, Multiplier, ALUOut,
        output Busy, Done, Product, ALU_FunSel, ALU_A, ALU_B, ALU_WF
    );

    modport master (
        output Start, Multiplicand, Multiplier, ALUOut,
        input  Busy, Done, Product, ALU_FunSel, ALU_A, ALU_B, ALU_WF
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Unsigned shift-and-add multiplier controller. Owns no adder: every add
//   and every left shift of the multiplicand is issued to the shared ALU,
//   whose registered result is captured one cycle after issue.
//   Ports:
//     Clock  - rising-edge clock
//     Reset  - asynchronous, active-high
//     bus    - alu_mul_sequencer_if.slave (request/result + ALU bus)
//   Optional build macro ALU_MUL_EARLY_EXIT_EN: finish as soon as the
//   remaining multiplier is zero instead of always running ITERS steps.
module alu_mul_sequencer #(
    parameter int OP_WIDTH = 16,
    parameter int ITERS    = OP_WIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset,
    alu_mul_sequencer_if.slave   bus
);
    localparam int PW = 2 * OP_WIDTH;
    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] ITERS_C = CW'(ITERS);

    localparam logic [4:0] FS_NOP = 5'b10000;
    localparam logic [4:0] FS_ADD = 5'b10100;
    localparam logic [4:0] FS_LSL = 5'b11011;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD_ISSUE,
        ADD_WAIT,
        SHIFT_ISSUE,
        SHIFT_WAIT,
        DONE
    } state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       p_q;        // accumulator
    logic [PW-1:0]       m_q;        // multiplicand, shifted left each step
    logic [OP_WIDTH-1:0] q_q;        // multiplier bits not yet consumed
    logic [CW-1:0]       cnt_q;
    logic [PW-1:0]       product_q;
    logic                check_done;

    logic [4:0]          fun_sel;
    logic [PW-1:0]       alu_a;
    logic [PW-1:0]       alu_b;

`ifdef ALU_MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations only shift M.
    assign check_done = (cnt_q == ITERS_C) || (q_q == '0);
`else
    assign check_done = (cnt_q == ITERS_C);
`endif

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (bus.Start) state_nx = CHECK;
            CHECK: begin
                if (check_done)  state_nx = DONE;
                else if (q_q[0]) state_nx = ADD_ISSUE;
                else             state_nx = SHIFT_ISSUE;
            end
            ADD_ISSUE:   state_nx = ADD_WAIT;
            ADD_WAIT:    state_nx = SHIFT_ISSUE;
            SHIFT_ISSUE: state_nx = SHIFT_WAIT;
            SHIFT_WAIT:  state_nx = CHECK;
            DONE:        state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    // Datapath registers. ALUOut is sampled in the WAIT state, i.e. on the
    // edge after the ALU latched the result of the preceding ISSUE cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            p_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        p_q   <= '0;
                        m_q   <= {{OP_WIDTH{1'b0}}, bus.Multiplicand};
                        q_q   <= bus.Multiplier;
                        cnt_q <= '0;
                    end
                end
                // Product is loaded on the edge entering DONE so it is
                // already valid while Done is high.
                CHECK:      if (check_done) product_q <= p_q;
                ADD_WAIT:   p_q <= bus.ALUOut;
                SHIFT_WAIT: begin
                    m_q   <= bus.ALUOut;
                    q_q   <= q_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // ALU drive: pure decode of state and registers
    always_comb begin
        fun_sel = FS_NOP;
        alu_a   = '0;
        alu_b   = '0;
        case (state)
            ADD_ISSUE: begin
                fun_sel = FS_ADD;
                alu_a   = p_q;
                alu_b   = m_q;
            end
            SHIFT_ISSUE: begin
                fun_sel = FS_LSL;
                alu_a   = m_q;
            end
            default: ;
        endcase
    end

    assign bus.ALU_FunSel = fun_sel;
    assign bus.ALU_A      = alu_a;
    assign bus.ALU_B      = alu_b;
    assign bus.ALU_WF     = 1'b0;     // never disturb ALU flags
    assign bus.Busy       = (state != IDLE);
    assign bus.Done       = (state == DONE);
    assign bus.Product    = product_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    localparam int W  = 16;
    localparam int PW = 32;

    logic Clock = 1'b0;
    logic Reset;
    int   cyc   = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    alu_mul_sequencer_if #(.OP_WIDTH(W)) bus();

    alu_mul_sequencer #(.OP_WIDTH(W), .ITERS(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Shared ALU model: result registered on the edge ending the issue cycle
    always @(posedge Clock) begin
        if (Reset) bus.ALUOut <= '0;
        else case (bus.ALU_FunSel)
            5'b10100: bus.ALUOut <= bus.ALU_A + bus.ALU_B;
            5'b11011: bus.ALUOut <= bus.ALU_A << 1;
            default:  ;
        endcase
    end

    typedef struct {
        logic [PW-1:0] prod;
        int            done_cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge index (relative to the accepting edge) after which Done is high
    function automatic int lat(input logic [W-1:0] q);
        int p;
        p = $countones(q);
`ifdef ALU_MUL_EARLY_EXIT_EN
        begin
            int h;
            h = -1;
            for (int i = 0; i < W; i++) if (q[i]) h = i;
            return 3 * (h + 1) + 2 * p + 1;
        end
`else
        return 3 * W + 2 * p + 1;
`endif
    endfunction

    // Monitor: pops the scoreboard on every Done
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) begin
            if (bus.Busy) check("alu_wf", {63'd0, bus.ALU_WF}, 64'd0);
            if (bus.Done) begin
                check("done_width", {63'd0, prev_done}, 64'd0);
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("product", bus.Product, e.prod);
                    check("done_cycle", cyc, e.done_cyc);
                end
            end
            prev_done = bus.Done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Waits for IDLE, presents operands with Start, returns the accept edge.
    // Start is left high; the caller decides when to drop it.
    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [PW-1:0] exp_prod, input bit push, output int acc);
        int t;
        t = 0;
        @(negedge Clock);
        while (bus.Busy !== 1'b0 && t < 200) begin
            @(negedge Clock);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got Busy=%b expected Busy=0", bus.Busy);
        end
        bus.Start        = 1'b1;
        bus.Multiplicand = m;
        bus.Multiplier   = q;
        @(posedge Clock);
        #1;
        acc = cyc;
        if (push) sbq.push_back('{exp_prod, acc + lat(q)});
    endtask

    task automatic drop_start();
        @(negedge Clock);
        bus.Start        = 1'b0;
        bus.Multiplicand = W'($urandom);
        bus.Multiplier   = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(negedge Clock);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [4:0] fs_exp [9];
    int acc, acc2;

    initial begin
        fs_exp = '{5'b10000, 5'b10100, 5'b10000, 5'b11011, 5'b10000,
                   5'b10000, 5'b10100, 5'b10000, 5'b11011};
        Reset            = 1'b1;
        bus.Start        = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;
        #1;
        check("rst_busy",   {63'd0, bus.Busy}, 64'd0);
        check("rst_done",   {63'd0, bus.Done}, 64'd0);
        check("rst_product", bus.Product, 64'd0);
        check("rst_funsel", bus.ALU_FunSel, 64'h10);
        check("rst_alu_a",  bus.ALU_A, 64'd0);
        check("rst_alu_b",  bus.ALU_B, 64'd0);
        check("rst_wf",     {63'd0, bus.ALU_WF}, 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // 7 * 3 with per-cycle ALU command trace
        issue(16'h0007, 16'h0003, 32'h0000_0015, 1, acc);
        for (int i = 0; i < 9; i++) begin
            if (i == 0) bus.Start = 1'b0;
            check($sformatf("funsel_%0d", i), bus.ALU_FunSel, fs_exp[i]);
            if (i == 1) begin
                check("add1_a", bus.ALU_A, 64'd0);
                check("add1_b", bus.ALU_B, 64'd7);
            end
            if (i == 6) begin
                check("add2_a", bus.ALU_A, 64'd7);
                check("add2_b", bus.ALU_B, 64'd14);
            end
            @(posedge Clock);
            #1;
        end
        drain();

        // Full-scale operands
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1, acc);
        drop_start();
        drain();

        // Zero operands
        issue(16'h1234, 16'h0000, 32'h0, 1, acc);
        drop_start();
        drain();
        issue(16'h0000, 16'h1234, 32'h0, 1, acc);
        drop_start();
        drain();
        issue(16'h1234, 16'h5678, 32'h0626_0060, 1, acc);
        drop_start();
        drain();

        // Start pulsed while busy must be ignored
        issue(16'h0005, 16'h0009, 32'h0000_002D, 1, acc);
        drop_start();
        repeat (5) @(negedge Clock);
        bus.Start        = 1'b1;
        bus.Multiplicand = 16'hAAAA;
        bus.Multiplier   = 16'h5555;
        @(negedge Clock);
        bus.Start        = 1'b0;
        drain();

        // Start held high: second op accepted on the IDLE cycle after DONE
        issue(16'h00FF, 16'h0100, 32'h0000_FF00, 1, acc);
        issue(16'h8000, 16'h0002, 32'h0001_0000, 1, acc2);
        check("b2b_accept", acc2, acc + lat(16'h0100) + 2);
        drop_start();
        drain();

        // Reset during ADD_WAIT abandons the operation
        issue(16'h0007, 16'h0003, 32'h0, 0, acc);
        bus.Start = 1'b0;
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_busy",   {63'd0, bus.Busy}, 64'd0);
        check("mid_rst_done",   {63'd0, bus.Done}, 64'd0);
        check("mid_rst_product", bus.Product, 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("post_rst_busy", {63'd0, bus.Busy}, 64'd0);
        repeat (60) @(negedge Clock);

        // Random pairs against the multiply model
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] m, q;
            m = W'($urandom);
            q = W'($urandom);
            issue(m, q, PW'(m) * PW'(q), 1, acc);
            drop_start();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
